pipeline_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/hazard_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default HALT encoding and the register-field bit ranges of an instruction.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_HALTED  = 2'd3;

  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the load sitting in EX produces a register that the
// instruction in ID wants to read, so ID must wait one cycle.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_uses_rt,
  input  logic [4:0] i_write_reg_e,
  input  logic       i_mem_to_reg_e,
  input  logic       i_reg_write_e,
  output logic       o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  // Register $0 is hard-wired, so a load "to $0" never creates a dependency.
  always_comb begin
    w_rs_match = (i_write_reg_e == i_rs);
    w_rt_match = i_uses_rt & (i_write_reg_e == i_rt);
    o_load_use = i_mem_to_reg_e & i_reg_write_e & (i_write_reg_e != 5'd0) &
                 (w_rs_match | w_rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Produces hold/clear controls and the PC enable from load-use, taken
// branches resolved in MEM, data-memory wait and HALT.
//
// Memory handshake: memReqM marks a MEM-stage access in the current cycle;
// memReadyM high in the same cycle completes it. A request without ready is a
// wait cycle, and the whole front of the pipeline (PC, IF/ID, ID/EX, EX/MEM)
// is held with a bubble pushed into WB until ready arrives.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEF
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instructionD,
  input  logic        usesRtD,
  input  logic [4:0]  writeRegE,
  input  logic        MemtoRegE,
  input  logic        RegWriteE,
  input  logic        branchTakenM,
  input  logic        memReqM,
  input  logic        memReadyM,
  output logic        pcWriteEn,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        refreshD,
  output logic        refreshE,
  output logic        refreshM,
  output logic        refreshW,
  output logic        haltDone,
  output logic [1:0]  dbg_state
);

  localparam int             CW       = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(DRAIN_CYCLES - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_halt_done;

  logic [1:0]    w_next_state;
  logic [CW-1:0] w_next_cnt;
  logic          w_mem_wait;
  logic          w_is_halt;
  logic          w_load_use;

  assign w_mem_wait = memReqM & ~memReadyM;
  assign w_is_halt  = (instructionD == HALT_INSTR);
  assign haltDone   = r_halt_done;
  assign dbg_state  = r_state;

  hazard_detect u_hazard_detect (
    .i_rs           (instructionD[RS_HI:RS_LO]),
    .i_rt           (instructionD[RT_HI:RT_LO]),
    .i_uses_rt      (usesRtD),
    .i_write_reg_e  (writeRegE),
    .i_mem_to_reg_e (MemtoRegE),
    .i_reg_write_e  (RegWriteE),
    .o_load_use     (w_load_use)
  );

  // State, drain counter and the registered halt-done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_halt_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_halt_done <= (w_next_state == ST_HALTED);
    end
  end

  // Next state and next counter value. MEMWAIT decodes like RUN: once ready
  // arrives the held instructions are evaluated afresh.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_RUN, ST_MEMWAIT: begin
        if (w_mem_wait) begin
          w_next_state = ST_MEMWAIT;
        end else if (branchTakenM) begin
          w_next_state = ST_RUN;
        end else if (w_is_halt) begin
          w_next_state = ST_DRAIN;
          w_next_cnt   = CNT_LOAD;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_mem_wait) begin
          w_next_state = ST_DRAIN;
        end else if (branchTakenM) begin
          // The HALT was on the wrong path; resume normal fetch.
          w_next_state = ST_RUN;
          w_next_cnt   = '0;
        end else if (r_cnt == '0) begin
          w_next_state = ST_HALTED;
        end else begin
          w_next_cnt   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_next_state = ST_HALTED;
      end
    endcase
  end

  // Pipeline-register controls decoded from state, counter and hazards.
  always_comb begin
    pcWriteEn = 1'b0;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    refreshD  = 1'b0;
    refreshE  = 1'b0;
    refreshM  = 1'b0;
    refreshW  = 1'b0;
    if (reset) begin
      refreshD = 1'b1;
      refreshE = 1'b1;
      refreshM = 1'b1;
      refreshW = 1'b1;
    end else begin
      case (r_state)
        ST_RUN, ST_MEMWAIT: begin
          pcWriteEn = 1'b1;
          if (w_mem_wait) begin
            pcWriteEn = 1'b0;
            stallF    = 1'b1;
            stallD    = 1'b1;
            stallE    = 1'b1;
            refreshW  = 1'b1;
          end else if (branchTakenM) begin
            refreshD  = 1'b1;
            refreshE  = 1'b1;
            refreshM  = 1'b1;
          end else if (w_is_halt || w_load_use) begin
            // HALT never enters EX; a load-use bubble lasts one cycle.
            pcWriteEn = 1'b0;
            stallF    = 1'b1;
            refreshE  = 1'b1;
          end
        end
        ST_DRAIN: begin
          stallF   = 1'b1;
          stallD   = 1'b1;
          refreshE = 1'b1;
          if (w_mem_wait) begin
            stallE   = 1'b1;
            refreshW = 1'b1;
            refreshE = 1'b0;
          end else if (branchTakenM) begin
            refreshD  = 1'b1;
            refreshM  = 1'b1;
            pcWriteEn = 1'b1;
            stallF    = 1'b0;
            stallD    = 1'b0;
          end
        end
        default: begin
          stallF   = 1'b1;
          stallD   = 1'b1;
          refreshE = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Each step drives inputs just after
// a rising edge, checks outputs and state at the falling edge, then advances.
module tb_pipeline_hazard_ctrl;

  // Output vector order: pc, sF, sD, sE, rD, rE, rM, rW, haltDone
  localparam logic [8:0] P_RST  = 9'b0_000_1111_0;
  localparam logic [8:0] P_RUN  = 9'b1_000_0000_0;
  localparam logic [8:0] P_LU   = 9'b0_100_0100_0;
  localparam logic [8:0] P_BR   = 9'b1_000_1110_0;
  localparam logic [8:0] P_FRZ  = 9'b0_111_0001_0;
  localparam logic [8:0] P_DRN  = 9'b0_110_0100_0;
  localparam logic [8:0] P_HLTD = 9'b0_110_0100_1;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_DR  = 2'd2;
  localparam logic [1:0] S_HL  = 2'd3;

  localparam logic [31:0] I_NOP      = 32'h0000_0000;
  localparam logic [31:0] I_ADD_8_1  = 32'h0101_4820; // add $9,$8,$1
  localparam logic [31:0] I_ADD_0_1  = 32'h0001_4820; // add $9,$0,$1
  localparam logic [31:0] I_ADD_1_8  = 32'h0028_4820; // add $9,$1,$8
  localparam logic [31:0] I_HALT     = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic [31:0] instructionD;
  logic        usesRtD;
  logic [4:0]  writeRegE;
  logic        MemtoRegE;
  logic        RegWriteE;
  logic        branchTakenM;
  logic        memReqM;
  logic        memReadyM;
  logic        pcWriteEn, stallF, stallD, stallE;
  logic        refreshD, refreshE, refreshM, refreshW, haltDone;
  logic [1:0]  dbg_state;
  logic [8:0]  w_obs;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .instructionD (instructionD),
    .usesRtD      (usesRtD),
    .writeRegE    (writeRegE),
    .MemtoRegE    (MemtoRegE),
    .RegWriteE    (RegWriteE),
    .branchTakenM (branchTakenM),
    .memReqM      (memReqM),
    .memReadyM    (memReadyM),
    .pcWriteEn    (pcWriteEn),
    .stallF       (stallF),
    .stallD       (stallD),
    .stallE       (stallE),
    .refreshD     (refreshD),
    .refreshE     (refreshE),
    .refreshM     (refreshM),
    .refreshW     (refreshW),
    .haltDone     (haltDone),
    .dbg_state    (dbg_state)
  );

  assign w_obs = {pcWriteEn, stallF, stallD, stallE,
                  refreshD, refreshE, refreshM, refreshW, haltDone};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample at the falling edge, compare, then move to just after the next rise.
  task automatic check(input string tag, input logic [8:0] exp_o, input logic [1:0] exp_s);
    @(negedge clk);
    n_checks++;
    assert (w_obs === exp_o) else begin
      n_errors++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, w_obs, exp_o);
    end
    n_checks++;
    assert (dbg_state === exp_s) else begin
      n_errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, dbg_state, exp_s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instructionD = I_NOP;
    usesRtD      = 1'b0;
    writeRegE    = 5'd0;
    MemtoRegE    = 1'b0;
    RegWriteE    = 1'b0;
    branchTakenM = 1'b0;
    memReqM      = 1'b0;
    memReadyM    = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    MemtoRegE = 1'b1;
    RegWriteE = 1'b1;
    writeRegE = rd;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset", P_RST, S_RUN);
    reset = 1'b0;
    check("run_default", P_RUN, S_RUN);

    // Load-use on rs: one bubble, then the load has left EX.
    instructionD = I_ADD_8_1; usesRtD = 1'b1; set_load(5'd8);
    check("lu_rs", P_LU, S_RUN);
    MemtoRegE = 1'b0; RegWriteE = 1'b0; writeRegE = 5'd0;
    check("lu_resolved", P_RUN, S_RUN);

    // No stall: load to $0, rt-only match without rt use, non-writing load.
    instructionD = I_ADD_0_1; usesRtD = 1'b1; set_load(5'd0);
    check("lu_reg0", P_RUN, S_RUN);
    instructionD = I_ADD_1_8; usesRtD = 1'b0; set_load(5'd8);
    check("lu_rt_unused", P_RUN, S_RUN);
    usesRtD = 1'b1;
    check("lu_rt_used", P_LU, S_RUN);
    instructionD = I_ADD_8_1; RegWriteE = 1'b0;
    check("lu_no_regwrite", P_RUN, S_RUN);
    idle_inputs();

    // Taken branch: one flush cycle, beats HALT in ID.
    branchTakenM = 1'b1;
    check("branch", P_BR, S_RUN);
    instructionD = I_HALT;
    check("branch_over_halt", P_BR, S_RUN);
    idle_inputs();
    check("branch_done", P_RUN, S_RUN);

    // Access completing in its first cycle never freezes.
    memReqM = 1'b1; memReadyM = 1'b1;
    check("mem_ready_now", P_RUN, S_RUN);

    // Three wait cycles with a pending branch; freeze wins, branch re-seen.
    memReadyM = 1'b0; branchTakenM = 1'b1;
    check("memwait_1", P_FRZ, S_RUN);
    check("memwait_2", P_FRZ, S_MW);
    check("memwait_3", P_FRZ, S_MW);
    memReadyM = 1'b1;
    check("memwait_release", P_BR, S_MW);
    idle_inputs();
    check("memwait_after", P_RUN, S_RUN);

    // HALT: detect cycle, three drain cycles, then halted and held.
    instructionD = I_HALT;
    check("halt_id", P_LU, S_RUN);
    check("drain_1", P_DRN, S_DR);
    check("drain_2", P_DRN, S_DR);
    check("drain_3", P_DRN, S_DR);
    check("halted_1", P_HLTD, S_HL);
    check("halted_2", P_HLTD, S_HL);

    // Reset out of HALTED.
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_halted", P_RST, S_RUN);
    reset = 1'b0; instructionD = I_NOP;
    check("run_after_reset", P_RUN, S_RUN);

    // HALT with a two-cycle memory wait in drain cycle 2.
    instructionD = I_HALT;
    check("hw_halt_id", P_LU, S_RUN);
    check("hw_drain_1", P_DRN, S_DR);
    memReqM = 1'b1; memReadyM = 1'b0;
    check("hw_wait_1", P_FRZ, S_DR);
    check("hw_wait_2", P_FRZ, S_DR);
    memReqM = 1'b0;
    check("hw_drain_2", P_DRN, S_DR);
    check("hw_drain_3", P_DRN, S_DR);
    check("hw_halted", P_HLTD, S_HL);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // HALT turns out wrong-path: branch during drain flushes back to RUN.
    instructionD = I_HALT;
    check("hb_halt_id", P_LU, S_RUN);
    check("hb_drain_1", P_DRN, S_DR);
    branchTakenM = 1'b1;
    check("hb_branch", P_BR, S_DR);
    idle_inputs();
    check("hb_run", P_RUN, S_RUN);

    // A later HALT drains the full length again.
    instructionD = I_HALT;
    check("h2_halt_id", P_LU, S_RUN);
    check("h2_drain_1", P_DRN, S_DR);
    check("h2_drain_2", P_DRN, S_DR);
    check("h2_drain_3", P_DRN, S_DR);
    check("h2_halted", P_HLTD, S_HL);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
